// File: rtl/mem_dma.sv
// Word-granular memory-to-memory copy engine: 4-register responder window plus a bus initiator.
// Optional constant-fill mode (CTRL bit3) is built when MEM_DMA_FILL_EN is defined.
//
// state  | meaning
// S_IDLE | no request outstanding; registers writable, waiting for a start
// S_RD   | read request on the bus at SRC
// S_WR   | write request on the bus at DST with the data register
module mem_dma #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           address_in,
  input  logic                  sel_in,
  input  logic                  read_in,
  output logic [31:0]           read_value_out,
  input  logic [3:0]            write_mask_in,
  input  logic [31:0]           write_value_in,
  output logic                  ready_out,
  output logic [ADDR_WIDTH-1:0] m_address_out,
  output logic                  m_read_out,
  output logic                  m_write_out,
  output logic [3:0]            m_write_mask_out,
  output logic [31:0]           m_write_value_out,
  input  logic [31:0]           m_read_value_in,
  input  logic                  m_ready_in,
  input  logic                  m_fault_in
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

  state_t                state;
  logic [ADDR_WIDTH-1:0] src, dst;
  logic [LEN_WIDTH-1:0]  len;
  logic                  done_q, fault_q, fill_q, busy;
  logic                  wr_en, ctrl_wr, start, fill_start;
  logic [1:0]            reg_sel;
  logic [ADDR_WIDTH-1:0] src_new, dst_new, src_inc, dst_inc;
  logic [LEN_WIDTH-1:0]  len_new;
  logic                  unused_addr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] mask);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = mask[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  assign busy        = (state != S_IDLE);
  assign reg_sel     = address_in[3:2];
  assign unused_addr = ^{address_in[31:4], address_in[1:0]};
  assign wr_en       = sel_in && (write_mask_in != 4'b0000);
  assign ctrl_wr     = wr_en && (reg_sel == 2'd3) && write_mask_in[0];
  assign start       = ctrl_wr && write_value_in[0] && !busy;
  assign ready_out   = sel_in;

  assign src_new = ADDR_WIDTH'(merge_bytes(32'(src), write_value_in, write_mask_in)) & WORD_MASK;
  assign dst_new = ADDR_WIDTH'(merge_bytes(32'(dst), write_value_in, write_mask_in)) & WORD_MASK;
  assign len_new = LEN_WIDTH'(merge_bytes(32'(len), write_value_in, write_mask_in));
  assign src_inc = src + WORD_STEP;
  assign dst_inc = dst + WORD_STEP;

`ifdef MEM_DMA_FILL_EN
  assign fill_start = write_value_in[3];

  // Mode only changes while idle so a running transfer keeps its mode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                fill_q <= 1'b0;
    else if (ctrl_wr && !busy) fill_q <= write_value_in[3];
  end
`else
  assign fill_start = 1'b0;
  assign fill_q     = 1'b0;
`endif

  always_comb begin
    read_value_out = '0;
    if (sel_in && read_in) begin
      case (reg_sel)
        2'd0:    read_value_out = 32'(src);
        2'd1:    read_value_out = 32'(dst);
        2'd2:    read_value_out = 32'(len);
        default: read_value_out = {28'd0, fill_q, fault_q, done_q, busy};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      src               <= '0;
      dst               <= '0;
      len               <= '0;
      done_q            <= 1'b0;
      fault_q           <= 1'b0;
      m_address_out     <= '0;
      m_read_out        <= 1'b0;
      m_write_out       <= 1'b0;
      m_write_mask_out  <= 4'b0000;
      m_write_value_out <= '0;
    end else begin
      // Clears come first so a hardware set in the same cycle wins.
      if (ctrl_wr && write_value_in[1]) done_q  <= 1'b0;
      if (ctrl_wr && write_value_in[2]) fault_q <= 1'b0;
      if (wr_en && !busy) begin
        case (reg_sel)
          2'd0:    src <= src_new;
          2'd1:    dst <= dst_new;
          2'd2:    len <= len_new;
          default: ;
        endcase
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len == '0) begin
              done_q <= 1'b1;
            end else if (fill_start) begin
              state             <= S_WR;
              m_write_out       <= 1'b1;
              m_write_mask_out  <= 4'b1111;
              m_address_out     <= dst;
              m_write_value_out <= 32'(src);
            end else begin
              state         <= S_RD;
              m_read_out    <= 1'b1;
              m_address_out <= src;
            end
          end
        end
        S_RD: begin
          if (m_ready_in) begin
            m_read_out <= 1'b0;
            if (m_fault_in) begin
              fault_q       <= 1'b1;
              state         <= S_IDLE;
              m_address_out <= '0;
            end else begin
              state             <= S_WR;
              m_write_out       <= 1'b1;
              m_write_mask_out  <= 4'b1111;
              m_address_out     <= dst;
              m_write_value_out <= m_read_value_in;
            end
          end
        end
        S_WR: begin
          if (m_ready_in) begin
            if (m_fault_in) begin
              fault_q          <= 1'b1;
              state            <= S_IDLE;
              m_write_out      <= 1'b0;
              m_write_mask_out <= 4'b0000;
              m_address_out    <= '0;
            end else begin
              if (!fill_q) src <= src_inc;
              dst <= dst_inc;
              len <= len - LEN_WIDTH'(1);
              if (len == LEN_WIDTH'(1)) begin
                done_q           <= 1'b1;
                state            <= S_IDLE;
                m_write_out      <= 1'b0;
                m_write_mask_out <= 4'b0000;
                m_address_out    <= '0;
              end else if (fill_q) begin
                m_address_out <= dst_inc;
              end else begin
                state            <= S_RD;
                m_write_out      <= 1'b0;
                m_write_mask_out <= 4'b0000;
                m_read_out       <= 1'b1;
                m_address_out    <= src_inc;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
